// File: rtl/fp32_cutoff_filter.sv
// Pair-stream cutoff filter: keeps pairs with r2 < cutoff^2 and buffers them in an output FIFO.
// Optional accept/reject statistics are built when CUTOFF_STATS_EN is defined.

module fp32_lessthan (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        lt
);
   logic a_nan;
   logic b_nan;
   logic both_zero;

   // IEEE-754 ordered less-than; NaN operands and +0/-0 pairs compare false
   always_comb begin
      a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
      lt        = 1'b0;
      if (a_nan || b_nan || both_zero) begin
         lt = 1'b0;
      end else if (a[31] != b[31]) begin
         lt = a[31];
      end else if (a[31]) begin
         lt = (a[30:0] > b[30:0]);
      end else begin
         lt = (a[30:0] < b[30:0]);
      end
   end
endmodule

module fp32_cutoff_filter #(
   parameter int ID_W  = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_we,
   input  logic [31:0]                cfg_cutoff_sq,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_r2,
   input  logic [ID_W-1:0]            in_id,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_r2,
   output logic [ID_W-1:0]            out_id,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
   output logic                       err_neg,
   output logic [31:0]                stat_accept,
   output logic [31:0]                stat_reject
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]     cutoff;
   logic            stage_valid;
   logic            stage_keep;
   logic [31:0]     stage_r2;
   logic [ID_W-1:0] stage_id;
   logic [31:0]     mem_r2 [DEPTH];
   logic [ID_W-1:0] mem_id [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW:0]     occupancy;
   logic            lt;
   logic            keep;
   logic            in_fire;
   logic            push;
   logic            pop;

   fp32_lessthan u_lt (
      .a  (in_r2),
      .b  (cutoff),
      .lt (lt)
   );

   // Handshakes and head view; the stage slot is reserved so a staged pair always has room
   always_comb begin
      occupancy  = {1'b0, count} + {{CW{1'b0}}, stage_valid};
      in_ready   = (occupancy < (CW+1)'(DEPTH));
      in_fire    = in_valid & in_ready;
      keep       = lt & ~in_r2[31] & (in_r2[30:23] != 8'hFF);
      push       = stage_valid & stage_keep;
      out_valid  = (count != '0);
      pop        = out_valid & out_ready;
      out_r2     = out_valid ? mem_r2[rd_ptr] : 32'd0;
      out_id     = out_valid ? mem_id[rd_ptr] : '0;
      fifo_count = count;
   end

   // Cutoff register; a same-cycle handshake still sees the old value
   always_ff @(posedge clk) begin
      if (rst) begin
         cutoff <= 32'h0000_0000;
      end else if (cfg_we) begin
         cutoff <= cfg_cutoff_sq;
      end
   end

   // One-entry compare stage and sticky negative-r2 flag
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid <= 1'b0;
         stage_keep  <= 1'b0;
         stage_r2    <= 32'd0;
         stage_id    <= '0;
         err_neg     <= 1'b0;
      end else begin
         stage_valid <= in_fire;
         if (in_fire) begin
            stage_keep <= keep;
            stage_r2   <= in_r2;
            stage_id   <= in_id;
            if (in_r2[31]) begin
               err_neg <= 1'b1;
            end
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r2[wr_ptr] <= stage_r2;
         mem_id[wr_ptr] <= stage_id;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef CUTOFF_STATS_EN
   logic [31:0] acc_cnt;
   logic [31:0] rej_cnt;

   // Wrapping accept/reject counters
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt <= 32'd0;
         rej_cnt <= 32'd0;
      end else begin
         if (push) begin
            acc_cnt <= acc_cnt + 32'd1;
         end
         if (stage_valid && !stage_keep) begin
            rej_cnt <= rej_cnt + 32'd1;
         end
      end
   end

   assign stat_accept = acc_cnt;
   assign stat_reject = rej_cnt;
`else
   assign stat_accept = 32'd0;
   assign stat_reject = 32'd0;
`endif

endmodule

// File: tb/tb_fp32_cutoff_filter.sv
// Scoreboard bench for fp32_cutoff_filter: kept pairs are queued at handshake and matched at output.
module tb_fp32_cutoff_filter;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH+1);

   localparam logic [31:0] F_0P0  = 32'h0000_0000;
   localparam logic [31:0] F_N0P0 = 32'h8000_0000;
   localparam logic [31:0] F_1P0  = 32'h3F80_0000;
   localparam logic [31:0] F_N1P0 = 32'hBF80_0000;
   localparam logic [31:0] F_1P5  = 32'h3FC0_0000;
   localparam logic [31:0] F_2P0  = 32'h4000_0000;
   localparam logic [31:0] F_5P0  = 32'h40A0_0000;
   localparam logic [31:0] F_10P0 = 32'h4120_0000;
   localparam logic [31:0] F_12P0 = 32'h4140_0000;
   localparam logic [31:0] F_INF  = 32'h7F80_0000;
   localparam logic [31:0] F_NAN  = 32'h7FC0_0000;

   logic          clk;
   logic          rst;
   logic          cfg_we;
   logic [31:0]   cfg_cutoff_sq;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_r2;
   logic [31:0]   in_id;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_r2;
   logic [31:0]   out_id;
   logic [CW-1:0] fifo_count;
   logic          err_neg;
   logic [31:0]   stat_accept;
   logic [31:0]   stat_reject;

   logic [63:0]   sb[$];
   int            errors;
   int            checks;
   int            exp_acc;
   int            exp_rej;

   fp32_cutoff_filter #(.ID_W(32), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_we        (cfg_we),
      .cfg_cutoff_sq (cfg_cutoff_sq),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_r2         (in_r2),
      .in_id         (in_id),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_r2        (out_r2),
      .out_id        (out_id),
      .fifo_count    (fifo_count),
      .err_neg       (err_neg),
      .stat_accept   (stat_accept),
      .stat_reject   (stat_reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: every head transfer must match the oldest expected pair
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            check("out_pair", {out_r2, out_id}, sb.pop_front());
         end
      end
   end

   task automatic check_stats(input string tag);
`ifdef CUTOFF_STATS_EN
      check({tag, "_acc"}, 64'(stat_accept), 64'(exp_acc));
      check({tag, "_rej"}, 64'(stat_reject), 64'(exp_rej));
`else
      check({tag, "_acc"}, 64'(stat_accept), 64'd0);
      check({tag, "_rej"}, 64'(stat_reject), 64'd0);
`endif
   endtask

   task automatic set_cutoff(input logic [31:0] v);
      cfg_we = 1'b1;
      cfg_cutoff_sq = v;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic send(input logic [31:0] r2, input logic [31:0] id, input bit kp);
      bit fired;
      fired = 1'b0;
      in_r2 = r2;
      in_id = id;
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !fired; t++) begin
         @(negedge clk);
         if (in_ready) begin
            fired = 1'b1;
            if (kp) begin
               sb.push_back({r2, id});
               exp_acc++;
            end else begin
               exp_rej++;
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("send_handshake", 64'(fired), 64'd1);
   endtask

   task automatic drain(input string tag);
      for (int t = 0; t < 200 && sb.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_drained"}, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int n;
      errors = 0; checks = 0; exp_acc = 0; exp_rej = 0;
      rst = 1'b1; cfg_we = 1'b0; cfg_cutoff_sq = 32'd0;
      in_valid = 1'b0; in_r2 = 32'd0; in_id = 32'd0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pair", {out_r2, out_id}, 64'd0);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_err_neg", 64'(err_neg), 64'd0);
      check_stats("rst");
      @(posedge clk); #1;
      rst = 1'b0;

      // T1: basic compare, strict less-than, two-cycle latency
      set_cutoff(F_10P0);
      out_ready = 1'b1;
      send(F_5P0, 32'd1, 1'b1);
      @(negedge clk);
      check("t1_lat_n1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("t1_lat_n2", 64'(out_valid), 64'd1);
      check("t1_head_r2", 64'(out_r2), 64'(F_5P0));
      @(posedge clk); #1;
      send(F_10P0, 32'd2, 1'b0);
      send(F_12P0, 32'd3, 1'b0);
      drain("t1");
      check_stats("t1");

      // T2: back-pressure fill, then in-order drain
      out_ready = 1'b0;
      n = 0;
      in_valid = 1'b1; in_r2 = F_1P0; in_id = 32'd100;
      for (int c = 0; c < DEPTH + 8; c++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back({F_1P0, 32'd100 + 32'(n)});
            exp_acc++;
            n++;
         end
         @(posedge clk); #1;
         in_id = 32'd100 + 32'(n);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("t2_accepted", 64'(n), 64'(DEPTH));
      check("t2_full_count", 64'(fifo_count), 64'(DEPTH));
      check("t2_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain("t2");
      check("t2_empty_count", 64'(fifo_count), 64'd0);
      check_stats("t2");

      // T3: negative, infinite and NaN distances
      check("t3_err_before", 64'(err_neg), 64'd0);
      send(F_N0P0, 32'd200, 1'b0);
      @(negedge clk);
      check("t3_err_first", 64'(err_neg), 64'd1);
      @(posedge clk); #1;
      send(F_N1P0, 32'd201, 1'b0);
      send(F_INF, 32'd202, 1'b0);
      send(F_NAN, 32'd203, 1'b0);
      drain("t3");
      check("t3_err_held", 64'(err_neg), 64'd1);
      check("t3_count", 64'(fifo_count), 64'd0);
      check_stats("t3");

      // T4: cutoff update coinciding with a handshake uses the old value
      set_cutoff(F_1P0);
      cfg_we = 1'b1; cfg_cutoff_sq = F_2P0;
      in_valid = 1'b1; in_r2 = F_1P5; in_id = 32'd300;
      @(negedge clk);
      check("t4_ready", 64'(in_ready), 64'd1);
      exp_rej++;
      @(posedge clk); #1;
      cfg_we = 1'b0; in_valid = 1'b0;
      send(F_1P5, 32'd301, 1'b1);
      drain("t4");
      check_stats("t4");

      // +0.0 passes a positive cutoff; a zero cutoff rejects everything
      send(F_0P0, 32'd400, 1'b1);
      set_cutoff(F_0P0);
      send(F_0P0, 32'd401, 1'b0);
      send(F_1P0, 32'd402, 1'b0);
      drain("t6");
      check_stats("t6");

      // T5: fill, then stream with the consumer ready every cycle
      set_cutoff(F_10P0);
      out_ready = 1'b0;
      n = 0;
      in_valid = 1'b1; in_r2 = F_1P0; in_id = 32'd1000;
      for (int c = 0; c < DEPTH + 30; c++) begin
         if (c == DEPTH + 2) out_ready = 1'b1;
         @(negedge clk);
         // Once streaming, occupancy settles at DEPTH-2: one slot stays reserved for the stage
         if (c >= DEPTH + 8) begin
            check("t5_in_ready", 64'(in_ready), 64'd1);
            check("t5_out_valid", 64'(out_valid), 64'd1);
            check("t5_count", 64'(fifo_count), 64'(DEPTH - 2));
         end
         if (in_ready) begin
            sb.push_back({F_1P0, 32'd1000 + 32'(n)});
            exp_acc++;
            n++;
         end
         @(posedge clk); #1;
         in_id = 32'd1000 + 32'(n);
      end
      rst = 1'b1;
      sb.delete();
      exp_acc = 0; exp_rej = 0;
      @(negedge clk);
      @(negedge clk);
      check("t5_rst_out_valid", 64'(out_valid), 64'd0);
      check("t5_rst_count", 64'(fifo_count), 64'd0);
      check("t5_rst_in_ready", 64'(in_ready), 64'd1);
      check("t5_rst_err_neg", 64'(err_neg), 64'd0);
      check_stats("t5_rst");
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      // cutoff was cleared by reset
      send(F_1P0, 32'd500, 1'b0);
      drain("t5");
      check_stats("t5_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
